// File: rtl/shared_adder_scheduler.sv
// shared_adder_scheduler: two requesters share one 16-bit ripple-carry adder.
// Each operation adds WORDS 16-bit slices serially, one slice per cycle.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   req0_* / req1_*             valid/ready request channels (a, b, cin)
//   resp_valid / resp_ready     response handshake
//   resp_sum, resp_cout         {cout, sum} = a + b + cin
//   resp_id                     requester that issued the result
//   busy                        controller not idle
//
// ripple_carry_16bit is the shared 16-bit adder datapath.

module ripple_carry_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    always_comb begin
        logic carry;
        carry = c_in;
        sum   = '0;
        for (int i = 0; i < 16; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

module shared_adder_scheduler #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [16*WORDS-1:0] req0_a,
    input  logic [16*WORDS-1:0] req0_b,
    input  logic                req0_cin,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [16*WORDS-1:0] req1_a,
    input  logic [16*WORDS-1:0] req1_b,
    input  logic                req1_cin,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [16*WORDS-1:0] resp_sum,
    output logic                resp_cout,
    output logic                resp_id,
    output logic                busy
);

    localparam int N  = 16 * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic          ptr;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          id_q;
    logic          carry_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  sum_q;
    logic          cout_q;

    logic [1:0]    grant;
    logic          accept;
    logic [15:0]   slice_a;
    logic [15:0]   slice_b;
    logic [15:0]   slice_sum;
    logic          slice_cout;

    // ptr=0 prefers req0 when both are valid, ptr=1 prefers req1.
    assign grant[0] = req0_valid & (~req1_valid | ~ptr);
    assign grant[1] = req1_valid & (~req0_valid | ptr);

    assign req0_ready = (state == IDLE) & grant[0];
    assign req1_ready = (state == IDLE) & grant[1];
    assign accept     = req0_ready | req1_ready;

    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);
    assign resp_sum   = sum_q;
    assign resp_cout  = cout_q;
    assign resp_id    = id_q;

    // Select operand slice k = cnt_q for the shared adder.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (cnt_q == CW'(k)) begin
                slice_a = a_q[16*k +: 16];
                slice_b = b_q[16*k +: 16];
            end
        end
    end

    ripple_carry_16bit u_adder (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= req1_ready ? req1_a : req0_a;
                        b_q     <= req1_ready ? req1_b : req0_b;
                        carry_q <= req1_ready ? req1_cin : req0_cin;
                        id_q    <= req1_ready;
                        // Next time both are valid, favour the other one.
                        ptr     <= req0_ready;
                        cnt_q   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (cnt_q == CW'(k)) begin
                            sum_q[16*k +: 16] <= slice_sum;
                        end
                    end
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cout_q <= slice_cout;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_adder_scheduler.sv
// tb_shared_adder_scheduler: self-checking bench for shared_adder_scheduler.
// Vector table, directed corner sequences and a randomized model comparison.

module tb_shared_adder_scheduler;

    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [N-1:0] req0_a = '0;
    logic [N-1:0] req0_b = '0;
    logic         req0_cin = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [N-1:0] req1_a = '0;
    logic [N-1:0] req1_b = '0;
    logic         req1_cin = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [N-1:0] resp_sum;
    logic         resp_cout;
    logic         resp_id;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    shared_adder_scheduler #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] sum;
        logic         cout;
    } vec_t;

    task automatic chk(input string name, input logic [N:0] act,
                       input logic [N:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] r;
        for (int i = 0; i < WORDS; i++) r[16*i +: 16] = 16'($urandom());
        return r;
    endfunction

    function automatic logic [N:0] model_add(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input logic cin);
        return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    endfunction

    task automatic set_req(input logic id, input logic v,
                           input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic cin);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // One complete operation; operands are scrambled right after the
    // handshake so only the latched values may influence the result.
    task automatic run_op(input string name, input vec_t v);
        int n;
        int t0;
        resp_ready = 1'b1;
        set_req(v.id, 1'b1, v.a, v.b, v.cin);
        #1;
        n = 0;
        while (!(v.id ? req1_ready : req0_ready) && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_grant"}, (N+1)'(n < 20), (N+1)'(1));
        t0 = cyc;
        tick();
        set_req(v.id, 1'b0, rnd(), rnd(), 1'($urandom()));
        n = 0;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, (N+1)'(cyc - t0), (N+1)'(WORDS + 1));
        chk({name, "_sum"}, {1'b0, resp_sum}, {1'b0, v.sum});
        chk({name, "_cout"}, (N+1)'(resp_cout), (N+1)'(v.cout));
        chk({name, "_id"}, (N+1)'(resp_id), (N+1)'(v.id));
        tick();
        chk({name, "_idle"}, (N+1)'(busy), (N+1)'(0));
    endtask

    initial begin
        vec_t vecs[6];
        logic [N-1:0] a0, b0, a1, b1;
        logic [N:0]   e0, e1;
        int gid[4], gcyc[4], rid[4];
        int ng, nr, n;
        bit both, seen;
        int phase, cnt;
        logic pref, g0, g1, v0, v1, cin, rr, eid;
        logic [N-1:0] ra, rb;
        logic [N:0]   exp_r;

        vecs[0] = '{1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                    64'h0001_0000_0000_0000, 1'b0};
        vecs[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
                    64'h0, 1'b1};
        vecs[2] = '{1'b0, 64'h0, 64'h0, 1'b1, 64'h1, 1'b0};
        vecs[3] = '{1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
                    1'b0, 64'h2345_6789_ABCD_F001, 1'b0};
        vecs[4] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    1'b1, 64'h1, 1'b1};
        vecs[5] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

        // Reset values
        tick();
        tick();
        chk("rst_resp_valid", (N+1)'(resp_valid), (N+1)'(0));
        chk("rst_busy", (N+1)'(busy), (N+1)'(0));
        rst = 1'b0;
        #1;
        chk("rst_sum", {1'b0, resp_sum}, (N+1)'(0));
        chk("rst_cout", (N+1)'(resp_cout), (N+1)'(0));
        chk("rst_id", (N+1)'(resp_id), (N+1)'(0));
        chk("rst_ready", (N+1)'({req0_ready, req1_ready}), (N+1)'(0));

        // Vector table
        for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // Round-robin with both valids held from reset
        do_reset();
        a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
        e0 = model_add(a0, b0, 1'b0);
        e1 = model_add(a1, b1, 1'b1);
        set_req(1'b0, 1'b1, a0, b0, 1'b0);
        set_req(1'b1, 1'b1, a1, b1, 1'b1);
        resp_ready = 1'b1;
        #1;
        ng = 0; nr = 0; both = 0;
        for (int c = 0; c < 60 && (ng < 4 || nr < 4); c++) begin
            if (req0_ready && req1_ready) both = 1;
            if ((req0_ready || req1_ready) && ng < 4) begin
                gid[ng] = int'(req1_ready);
                gcyc[ng] = cyc;
                ng++;
            end
            if (resp_valid && nr < 4) begin
                rid[nr] = int'(resp_id);
                chk($sformatf("rr_sum%0d", nr), {resp_cout, resp_sum},
                    resp_id ? e1 : e0);
                nr++;
            end
            tick();
        end
        chk("rr_both_ready", (N+1)'(both), (N+1)'(0));
        chk("rr_grants", (N+1)'(ng), (N+1)'(4));
        chk("rr_resps", (N+1)'(nr), (N+1)'(4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_gid%0d", i), (N+1)'(gid[i]), (N+1)'(i % 2));
            chk($sformatf("rr_rid%0d", i), (N+1)'(rid[i]), (N+1)'(i % 2));
            if (i > 0)
                chk($sformatf("rr_gap%0d", i), (N+1)'(gcyc[i] - gcyc[i-1]),
                    (N+1)'(WORDS + 2));
        end

        // Backpressure
        do_reset();
        a0 = rnd(); b0 = rnd();
        e0 = model_add(a0, b0, 1'b1);
        set_req(1'b0, 1'b1, a0, b0, 1'b1);
        #1;
        chk("bp_ready0", (N+1)'(req0_ready), (N+1)'(1));
        tick();
        req1_valid = 1'b1;
        n = 0;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp_valid", (N+1)'(resp_valid), (N+1)'(1));
        for (int i = 0; i < 10; i++) begin
            chk("bp_result", {resp_cout, resp_sum}, e0);
            chk("bp_id", (N+1)'(resp_id), (N+1)'(0));
            chk("bp_readys", (N+1)'({req0_ready, req1_ready}), (N+1)'(0));
            chk("bp_busy", (N+1)'({busy, resp_valid}), (N+1)'(3));
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("bp_release", (N+1)'({busy, resp_valid}), (N+1)'(0));

        // Reset mid-operation of a req1 transfer
        do_reset();
        set_req(1'b1, 1'b1, rnd(), rnd(), 1'b0);
        #1;
        chk("mid_ready1", (N+1)'(req1_ready), (N+1)'(1));
        tick();
        req1_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_busy", (N+1)'(busy), (N+1)'(0));
        tick();
        rst = 1'b0;
        resp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) seen = 1;
            tick();
        end
        chk("mid_no_resp", (N+1)'(seen), (N+1)'(0));
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mid_prefer0", (N+1)'({req0_ready, req1_ready}), (N+1)'(2));

        // Randomized comparison against a transaction-level model
        do_reset();
        phase = 0; cnt = 0; pref = 1'b0;
        eid = 1'b0; exp_r = '0;
        for (int c = 0; c < 400; c++) begin
            v0 = 1'($urandom()); v1 = 1'($urandom());
            ra = rnd(); rb = rnd(); cin = 1'($urandom());
            rr = ($urandom_range(3) != 0);
            set_req(1'b0, v0, ra, rb, cin);
            set_req(1'b1, v1, ~ra, rb ^ 64'h5A5A, ~cin);
            resp_ready = rr;
            #1;
            g0 = 1'b0; g1 = 1'b0;
            if (phase == 0) begin
                if (v0 && v1) begin g0 = ~pref; g1 = pref; end
                else begin g0 = v0; g1 = v1; end
            end
            chk("rnd_ready", (N+1)'({req0_ready, req1_ready}),
                (N+1)'({g0, g1}));
            chk("rnd_status", (N+1)'({busy, resp_valid}),
                (N+1)'({phase != 0, phase == 2}));
            if (phase == 2) begin
                chk("rnd_result", {resp_cout, resp_sum}, exp_r);
                chk("rnd_id", (N+1)'(resp_id), (N+1)'(eid));
            end
            @(posedge clk);
            if (phase == 0) begin
                if (g0 || g1) begin
                    exp_r = g1 ? model_add(~ra, rb ^ 64'h5A5A, ~cin)
                               : model_add(ra, rb, cin);
                    eid = g1;
                    pref = ~g1;
                    phase = 1;
                    cnt = WORDS;
                end
            end else if (phase == 1) begin
                cnt--;
                if (cnt == 0) phase = 2;
            end else if (rr) begin
                phase = 0;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_adder_scheduler.md
# shared_adder_scheduler

Sequencing and arbitration controller that shares a single `ripple_carry_16bit` instance between two requesters. It performs multi-word additions (16·WORDS bits) serially, one 16-bit slice per cycle, carrying through a carry register. Requesters are served round-robin over valid/ready handshakes, and results are returned on a single response channel tagged with the requester id. It sits between arithmetic clients and the 16-bit adder datapath. The adder is instantiated inside the block.

## Interface
- WORDS, 4, number of 16-bit slices per operand (≥1); operand width N = 16·WORDS
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  N  operands
- req0_cin  in  1  carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_sum  out  N  sum
- resp_cout  out  1  final carry-out
- resp_id  out  1  requester that issued this result
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - grant = round-robin choice among asserted valids.
  - Pointer prefers req0 after reset; it flips to prefer the other requester after each grant.
  - Only the granted requester sees ready=1, combinationally: `reqX_ready = (state==IDLE) & grant[X]`.
  - Ready is 0 in RUN and DONE.
- Handshake (valid & ready):
  - Latch a, b, and id.
  - Carry register ← cin.
  - Slice counter ← 0.
  - Go to RUN.
- RUN, each cycle:
  - Adder inputs: a[16k+15:16k], b[16k+15:16k], and the carry register, where k = counter.
  - Sum slice k is written into the result register.
  - Carry register ← adder c_out.
  - Counter increments.
  - When k = WORDS-1: resp_cout ← c_out, go to DONE.
- DONE:
  - resp_valid=1.
  - resp_sum, resp_cout, and resp_id are held stable until resp_ready=1, then go to IDLE.
  - No new request is accepted in the same cycle as response acceptance.
- Arithmetic: {resp_cout, resp_sum} = a + b + cin, modulo 2^(N+1). The result is unsigned. No overflow flag.
- Requester inputs are sampled only at the handshake. Changes after the handshake have no effect.
- A requester that drops valid before being granted loses nothing. There is no request queue.

## Timing
- Reset values:
  - State IDLE, pointer prefers req0, counter 0, carry 0.
  - resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0, busy=0.
  - reqX_ready follows the IDLE grant logic (0 when no valid is asserted).
- Handshake in cycle T:
  - RUN occupies T+1 … T+WORDS.
  - resp_valid is high from T+WORDS+1.
- If resp_ready is high at T+WORDS+1:
  - IDLE at T+WORDS+2.
  - Next ready can be asserted at T+WORDS+2.
  - Peak throughput is one operation per WORDS+2 cycles.
- WORDS=1: a single RUN cycle; resp_valid at T+2.
- Both valids high in IDLE: exactly one ready is asserted, as chosen by the pointer. The loser's ready stays 0.
- Backpressure: while resp_ready=0, the block holds in DONE indefinitely. Outputs are stable and both readys stay 0.
- resp_sum slices for indices < k may update during RUN. They are only meaningful while resp_valid=1.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate (asynchronous) return to reset values.
  - The in-flight operation is discarded and no response is issued.
  - The pointer returns to prefer req0.

## Test plan
- Cross-slice carry, WORDS=4: req0 issues a=0x0000_FFFF_FFFF_FFFF, b=0x1, cin=0 at T → resp_valid at T+5, resp_sum=0x0001_0000_0000_0000, resp_cout=0, resp_id=0.
- Full overflow and carry-in:
  - a=0xFFFF_FFFF_FFFF_FFFF, b=0x0, cin=1 → resp_sum=0, resp_cout=1.
  - a=b=0, cin=1 → resp_sum=0x1, resp_cout=0.
- Round-robin: both valids held high continuously from reset with resp_ready=1 → grants alternate 0,1,0,1. resp_id follows the same sequence. Successive handshakes are 6 cycles apart.
- Backpressure: hold resp_ready=0 for 10 cycles after resp_valid → resp_sum, resp_cout, and resp_id are unchanged. Both readys stay 0 and busy=1. Raise resp_ready → IDLE the next cycle.
- Reset mid-operation: assert rst at T+2 of a req1 operation → resp_valid never rises for it, busy=0 immediately. After release, with both valids high, req0 is granted first.
- Operand isolation: change req0_a/b on the cycle after the handshake → result matches the values latched at the handshake.
